fp_to_q20_stage: RTL and testbench

- Pipelined IEEE-754 single-precision to signed Q1.20 (21-bit) converter.
- Sits directly upstream of the 16-stage CORDIC rotation pipeline and feeds its z0 angle input.
- Adds a valid sideband, saturation and NaN flags, and optional round-to-nearest-even.
- Replaces the purely combinational float-to-fixed path so the angle input is registered and qualified.

---
 rtl/fp_to_q20_stage.sv | 201 ++++++++++++++++++++
 tb/tb_fp_to_q20_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_q20_stage.sv
// fp_to_q20_stage: 3-stage IEEE-754 single -> signed Q1.20 converter feeding the CORDIC z0 angle input.
// Define FP_TO_Q20_ROUND_NEAREST_EN for round-half-even; the default build truncates toward zero.
module fp_to_q20_stage #(
  parameter int OUT_W  = 21,
  parameter int FRAC_W = 20
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [31:0]      dataa,
  output logic             out_valid,
  output logic [OUT_W-1:0] result,
  output logic             sat,
  output logic             nan
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_BIG,
    CLS_INF,
    CLS_NAN
  } cls_e;

  localparam logic [7:0] EXP_NORM_MIN = 8'd105;
  localparam logic [7:0] EXP_ONE      = 8'd127;
  localparam logic [7:0] EXP_SPECIAL  = 8'd255;
  // m * 2^(e-150) expressed in units of 2^-FRAC_W is m >> (SHIFT_BIAS - e).
  localparam logic [7:0] SHIFT_BIAS   = 8'(150 - FRAC_W);

  localparam logic [OUT_W-1:0] MAG_ONE = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {FRAC_W{1'b1}}};

  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  assign in_exp  = dataa[30:23];
  assign in_frac = dataa[22:0];

  // ---------------------------------------------------------------- S1 decode
  logic        s1_valid_d,  s1_valid_q;
  logic        s1_sign_d,   s1_sign_q;
  logic [7:0]  s1_exp_d,    s1_exp_q;
  logic [23:0] s1_mant_d,   s1_mant_q;
  logic        s1_is_one_d, s1_is_one_q;
  cls_e        s1_cls_d,    s1_cls_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s1_valid_d  = in_valid;
    s1_sign_d   = dataa[31];
    s1_exp_d    = in_exp;
    s1_mant_d   = {(in_exp != 8'd0), in_frac};
    s1_is_one_d = (in_exp == EXP_ONE) && (in_frac == 23'd0);
    s1_cls_d    = CLS_ZERO;
    if (in_exp == EXP_SPECIAL) begin
      s1_cls_d = (in_frac != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (in_exp >= EXP_ONE) begin
      s1_cls_d = CLS_BIG;
    end else if (in_exp >= EXP_NORM_MIN) begin
      s1_cls_d = CLS_NORMAL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  // NOTE: data registers are reset as well as valid bits, because aclr must force result/sat/nan to 0.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_is_one_q <= 1'b0;
      s1_cls_q    <= CLS_ZERO;
    end else if (clk_en) begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_is_one_q <= s1_is_one_d;
      s1_cls_q    <= s1_cls_d;
    end
  end

  // ------------------------------------------------------------- S2 magnitude
  logic             s2_valid_d,    s2_valid_q;
  logic             s2_sign_d,     s2_sign_q;
  logic             s2_nan_d,      s2_nan_q;
  logic             s2_hard_ovf_d, s2_hard_ovf_q;
  logic [OUT_W-1:0] s2_mag_d,      s2_mag_q;
  logic             s2_round_up_d, s2_round_up_q;

  logic [7:0]        shamt;
  logic [FRAC_W-1:0] shifted;

`ifdef FP_TO_Q20_ROUND_NEAREST_EN
  logic [7:0]  guard_idx;
  logic [24:0] guard_sel;
  logic [24:0] below_guard;
  logic        guard_bit;
  logic        sticky_bit;
`endif

  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_sign_d     = s1_sign_q;
    s2_nan_d      = (s1_cls_q == CLS_NAN);
    // Beyond +/-1.0 in a way that can never be the exact -1.0 encoding.
    s2_hard_ovf_d = (s1_cls_q == CLS_INF) || ((s1_cls_q == CLS_BIG) && !s1_is_one_q);
    s2_mag_d      = '0;
    s2_round_up_d = 1'b0;
    shamt         = SHIFT_BIAS - s1_exp_q;
    // For NORMAL the shift is at least 4, so the top bits of the 24-bit result are always zero.
    shifted       = FRAC_W'(s1_mant_q >> shamt);

`ifdef FP_TO_Q20_ROUND_NEAREST_EN
    // Guard index may reach 24 (one past the mantissa); the zero-extended bit reads as 0 there.
    guard_idx   = shamt - 8'd1;
    guard_sel   = 25'd1 << guard_idx;
    below_guard = guard_sel - 25'd1;
    guard_bit   = |({1'b0, s1_mant_q} & guard_sel);
    sticky_bit  = |({1'b0, s1_mant_q} & below_guard);
`endif

    case (s1_cls_q)
      CLS_NORMAL: begin
        s2_mag_d = {1'b0, shifted};
`ifdef FP_TO_Q20_ROUND_NEAREST_EN
        s2_round_up_d = guard_bit & (sticky_bit | shifted[0]);
`endif
      end
      CLS_BIG, CLS_INF: s2_mag_d = MAG_ONE;
      default:          s2_mag_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_nan_q      <= 1'b0;
      s2_hard_ovf_q <= 1'b0;
      s2_mag_q      <= '0;
      s2_round_up_q <= 1'b0;
    end else if (clk_en) begin
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_nan_q      <= s2_nan_d;
      s2_hard_ovf_q <= s2_hard_ovf_d;
      s2_mag_q      <= s2_mag_d;
      s2_round_up_q <= s2_round_up_d;
    end
  end

  // -------------------------------------------------------- S3 sign/saturate
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] result_d,    result_q;
  logic             sat_d,       sat_q;
  logic             nan_d,       nan_q;
  logic [OUT_W-1:0] mag_rnd;

  always_comb begin
    // mag_q never exceeds 2^FRAC_W - 1 when a round-up is pending, so this cannot wrap.
    mag_rnd     = s2_mag_q + OUT_W'(s2_round_up_q);
    out_valid_d = s2_valid_q;
    nan_d       = s2_nan_q;
    sat_d       = 1'b0;
    result_d    = s2_sign_q ? (-mag_rnd) : mag_rnd;
    if (mag_rnd[FRAC_W]) begin
      if (s2_sign_q) begin
        // -1.0 is representable; only a true |x| > 1 (or -inf) is a saturation.
        result_d = MAG_ONE;
        sat_d    = s2_hard_ovf_q;
      end else begin
        result_d = POS_MAX;
        sat_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else if (clk_en) begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      nan_q       <= nan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;
  assign nan       = nan_q;

endmodule

// File: tb/tb_fp_to_q20_stage.sv
// Self-checking bench for fp_to_q20_stage: directed spec vectors, stall, mid-stream reset and
// randomized operands checked against a real-arithmetic reference model.
module tb_fp_to_q20_stage;

  localparam int LAT = 3;
  localparam int ND  = 17;
`ifdef FP_TO_Q20_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clock    = 1'b0;
  logic        aclr     = 1'b1;
  logic        clk_en   = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] dataa    = 32'h0;
  logic        out_valid;
  logic [20:0] result;
  logic        sat;
  logic        nan;

  int n_checks = 0;
  int n_fail   = 0;
  int en_edges = 0;
  bit last_en  = 1'b0;

  typedef struct {
    logic [31:0] x;
    logic [20:0] res;
    logic        sat;
    logic        nan;
    int          issue;
  } exp_t;

  exp_t exp_q[$];

  // Directed operands and expected {result, sat, nan}.
  logic [31:0] dir_x [ND] = '{
    32'h3F000000, 32'hBE800000, 32'hBF800000, 32'h3F800000, 32'h40490FDB,
    32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h33800000, 32'h00000001,
    32'h3F7FFFFF, 32'h3A800000, 32'hBF7FFFFF, 32'h7F800000, 32'hC0000000,
    32'hFFC00001, 32'h3E000000
  };
  logic [22:0] dir_exp [ND] = '{
    {21'h080000, 2'b00}, {21'h1C0000, 2'b00}, {21'h100000, 2'b00}, {21'h0FFFFF, 2'b10},
    {21'h0FFFFF, 2'b10}, {21'h100000, 2'b10}, {21'h000000, 2'b00}, {21'h000000, 2'b01},
    {21'h000000, 2'b00}, {21'h000000, 2'b00},
    {21'h0FFFFF, (RND ? 2'b10 : 2'b00)},
    {21'h000400, 2'b00},
    {(RND ? 21'h100000 : 21'h100001), 2'b00},
    {21'h0FFFFF, 2'b10}, {21'h100000, 2'b10}, {21'h000000, 2'b01}, {21'h020000, 2'b00}
  };

  fp_to_q20_stage dut (
    .clock    (clock),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .in_valid (in_valid),
    .dataa    (dataa),
    .out_valid(out_valid),
    .result   (result),
    .sat      (sat),
    .nan      (nan)
  );

  always #5 clock = ~clock;

  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  // Reference: exact value of the float scaled by 2^20, rounded as the build selects, then clamped.
  function automatic void model(input logic [31:0] x, output logic [20:0] r,
                                output logic s_o, output logic n_o);
    int  e, fr, qi;
    real a, q;
    bit  neg;
    e   = int'({24'd0, x[30:23]});
    fr  = int'({9'd0, x[22:0]});
    neg = x[31];
    r   = '0;
    s_o = 1'b0;
    n_o = 1'b0;
    if (e == 255 && fr != 0) begin
      n_o = 1'b1;
      return;
    end
    if (e == 255)     a = 1.0e30;
    else if (e == 0)  a = real'(fr) * pow2(1 - 130);
    else              a = real'(fr + (1 << 23)) * pow2(e - 130);
    if (a >= 2097152.0) q = a;
    else begin
      q = real'($rtoi(a));
`ifdef FP_TO_Q20_ROUND_NEAREST_EN
      if ((a - q > 0.5) || ((a - q == 0.5) && (($rtoi(q) % 2) == 1))) q = q + 1.0;
`endif
    end
    if (q >= 1048576.0) begin
      r   = neg ? 21'h100000 : 21'h0FFFFF;
      s_o = neg ? (a > 1048576.0) : 1'b1;
    end else begin
      qi = $rtoi(q);
      r  = neg ? 21'(-qi) : 21'(qi);
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] f;
    int          g;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'($urandom);
      3: begin e = 8'd126; f = '1; end
      4: begin
        // Exact half-way case: guard bit set, everything below it clear.
        e = 8'($urandom_range(120, 126));
        g = 129 - int'({24'd0, e});
        f = (f & ~23'((1 << (g + 1)) - 1)) | 23'(1 << g);
      end
      default: e = 8'($urandom_range(103, 128));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Advance one cycle; operands accepted on an enabled edge enter the expectation queue.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    last_en = clk_en;
    if (clk_en === 1'b1) begin
      if (in_valid === 1'b1) begin
        e.x     = dataa;
        e.issue = en_edges;
        model(dataa, e.res, e.sat, e.nan);
        exp_q.push_back(e);
      end
      en_edges++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    clk_en   = 1'b1;
    in_valid = 1'b1;
    dataa    = 32'h3F000000;
    #1 aclr  = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({out_valid, result, sat, nan} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b result=%h sat=%b nan=%b, want all 0",
               out_valid, result, sat, nan);
    end
    in_valid = 1'b0;
    aclr     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_directed();
    int   j = 0;
    exp_t e;
    for (int i = 0; i < ND + LAT + 2; i++) begin
      clk_en = 1'b1;
      if (i < ND) begin
        in_valid = 1'b1;
        dataa    = dir_x[i];
      end else begin
        in_valid = 1'b0;
        dataa    = 32'h0;
      end
      tick();
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || en_edges - exp_q[0].issue != LAT || j >= ND) begin
          n_fail++;
          $display("FAIL dir_timing: out_valid=1 with no operand due (queued=%0d)", exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if ({result, sat, nan} !== dir_exp[j]) begin
            n_fail++;
            $display("FAIL dir_value: x=%h got result=%h sat=%b nan=%b, want result=%h sat=%b nan=%b",
                     e.x, result, sat, nan, dir_exp[j][22:2], dir_exp[j][1], dir_exp[j][0]);
          end
          j++;
        end
      end else if (exp_q.size() != 0 && en_edges - exp_q[0].issue >= LAT) begin
        n_checks++;
        n_fail++;
        $display("FAIL dir_missing: x=%h got out_valid=0 want 1", exp_q[0].x);
        exp_q.delete(0);
      end
    end
    n_checks++;
    if (j != ND) begin
      n_fail++;
      $display("FAIL dir_count: got %0d results want %0d", j, ND);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ops  [3] = '{32'h3F000000, 32'hBF000000, 32'h3E000000};
    logic [20:0] want [3] = '{21'h080000, 21'h180000, 21'h020000};
    bit          en_s [11] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    int          op_s [11] = '{0, 1, 2, 2, 2, -1, -1, -1, -1, -1, -1};
    int          k = 0;
    logic [23:0] held;
    exp_t        e;
    held = {out_valid, result, sat, nan};
    for (int i = 0; i < 11; i++) begin
      clk_en   = en_s[i];
      in_valid = (op_s[i] >= 0);
      dataa    = (op_s[i] >= 0) ? ops[op_s[i]] : 32'h0;
      tick();
      if (!last_en) begin
        n_checks++;
        if ({out_valid, result, sat, nan} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: cycle %0d got %h want held %h", i,
                   {out_valid, result, sat, nan}, held);
        end
      end else if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || en_edges - exp_q[0].issue != LAT || k >= 3) begin
          n_fail++;
          $display("FAIL stall_timing: cycle %0d out_valid=1 with no operand due", i);
        end else begin
          e = exp_q.pop_front();
          if ({result, sat, nan} !== {want[k], 2'b00}) begin
            n_fail++;
            $display("FAIL stall_value: item %0d got result=%h sat=%b nan=%b want result=%h sat=0 nan=0",
                     k, result, sat, nan, want[k]);
          end
          k++;
        end
      end else if (exp_q.size() != 0 && en_edges - exp_q[0].issue >= LAT) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_missing: x=%h got out_valid=0 want 1", exp_q[0].x);
        exp_q.delete(0);
      end
      held = {out_valid, result, sat, nan};
    end
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results want 3", k);
    end
  endtask

  task automatic test_random();
    localparam int NR = 500;
    logic [23:0] prev;
    exp_t        e;
    prev = {out_valid, result, sat, nan};
    for (int i = 0; i < NR + 8; i++) begin
      if (i < NR) begin
        clk_en   = ($urandom_range(0, 4) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        dataa    = rand_operand();
      end else begin
        clk_en   = 1'b1;
        in_valid = 1'b0;
      end
      tick();
      if (!last_en) begin
        n_checks++;
        if ({out_valid, result, sat, nan} !== prev) begin
          n_fail++;
          $display("FAIL rand_hold: cycle %0d got %h want held %h", i,
                   {out_valid, result, sat, nan}, prev);
        end
      end else if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || en_edges - exp_q[0].issue != LAT) begin
          n_fail++;
          $display("FAIL rand_timing: cycle %0d out_valid=1 with no operand due (queued=%0d)",
                   i, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if ({result, sat, nan} !== {e.res, e.sat, e.nan}) begin
            n_fail++;
            $display("FAIL rand_value: x=%h got result=%h sat=%b nan=%b, want result=%h sat=%b nan=%b",
                     e.x, result, sat, nan, e.res, e.sat, e.nan);
          end
        end
      end else if (exp_q.size() != 0 && en_edges - exp_q[0].issue >= LAT) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_missing: x=%h got out_valid=0 want 1", exp_q[0].x);
        exp_q.delete(0);
      end
      prev = {out_valid, result, sat, nan};
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d operands never delivered want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    clk_en   = 1'b1;
    in_valid = 1'b1;
    dataa    = 32'hFF800000;
    while (out_valid !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_fill: got out_valid=%b after %0d cycles want 1", out_valid, waited);
    end
    in_valid = 1'b0;
    #2 aclr = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (result !== 21'h0) begin
      n_fail++;
      $display("FAIL midrst_result: got %h want 000000", result);
    end
    n_checks++;
    if (sat !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_sat: got %b want 0", sat);
    end
    n_checks++;
    if (nan !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_nan: got %b want 0", nan);
    end
    #1 aclr = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale: cycle %0d got out_valid=%b result=%h want out_valid=0",
                 i, out_valid, result);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
